// File: rtl/calc_entry.sv
// Keypad entry accumulator: builds a BCD number from key codes, then
// left-normalizes it one digit per cycle and offers it on valid/ready.

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int SigW      = 4 * NumDigits;
  localparam int ExpW      = 8;

  // value = sig * 10^(exp - ExpBias); nibble NumDigits-1 of sig is the MSD
  typedef struct packed {
    logic            sign;
    logic [SigW-1:0] sig;
    logic [ExpW-1:0] exp;
    logic            error;
  } num_t;
endpackage

module calc_entry
  import calc_pkg::*;
#(
  parameter int ExpBias = NumDigits
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] key_i,
  input  logic       key_valid_i,
  output logic       key_ready_o,
  output num_t       entry_o,
  output num_t       num_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  localparam int CntW = $clog2(NumDigits + 1);
  localparam logic [ExpW-1:0] Bias = ExpW'(ExpBias);

  typedef enum logic [1:0] {S_ENTRY, S_NORMALIZE, S_OUTPUT} state_t;

  state_t          state, state_d;
  num_t            work, work_d;
  logic            sign;
  logic [SigW-1:0] sig;
  logic [CntW-1:0] dig_cnt, frac_cnt;
  logic            point;
  logic            key_acc, out_acc, is_digit;

  // key_ready_o tracks S_ENTRY exactly, so the handshake needs no state term
  assign key_acc  = key_valid_i & key_ready_o;
  assign out_acc  = out_valid_o & out_ready_i;
  assign is_digit = (key_i <= 4'd9);

  assign entry_o = '{sign: sign, sig: sig, exp: Bias - ExpW'(frac_cnt), error: 1'b0};
  assign num_o   = out_valid_o ? work : '0;

  // Entry registers: updated by accepted keys, cleared when the operand is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign     <= 1'b0;
      sig      <= '0;
      dig_cnt  <= '0;
      frac_cnt <= '0;
      point    <= 1'b0;
    end else if (state == S_OUTPUT && out_acc) begin
      sign     <= 1'b0;
      sig      <= '0;
      dig_cnt  <= '0;
      frac_cnt <= '0;
      point    <= 1'b0;
    end else if (key_acc) begin
      if (is_digit) begin
        // leading zeros before the point carry no information; full entry drops digits
        if (!(dig_cnt == '0 && key_i == 4'd0 && !point) && dig_cnt < CntW'(NumDigits)) begin
          sig     <= {sig[SigW-5:0], key_i};
          dig_cnt <= dig_cnt + 1'b1;
          if (point) frac_cnt <= frac_cnt + 1'b1;
        end
      end else begin
        case (key_i)
          4'hA: point <= 1'b1;
          4'hB: sign  <= ~sign;
          4'hC: begin
            sign     <= 1'b0;
            sig      <= '0;
            dig_cnt  <= '0;
            frac_cnt <= '0;
            point    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state and work-register update
  always_comb begin
    state_d = state;
    work_d  = work;
    case (state)
      S_ENTRY: begin
        if (key_acc && key_i == 4'hD) begin
          work_d  = entry_o;
          state_d = S_NORMALIZE;
        end
      end
      S_NORMALIZE: begin
        if (work.exp != '0 && work.sig[SigW-1 -: 4] == 4'd0) begin
          work_d.sig = {work.sig[SigW-5:0], 4'd0};
          work_d.exp = work.exp - 1'b1;
        end else begin
          if (work.sig == '0) work_d.sign = 1'b0;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_acc) state_d = S_ENTRY;
      end
      default: state_d = S_ENTRY;
    endcase
  end

  // State, work register and registered handshake flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_ENTRY;
      work        <= '0;
      key_ready_o <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      state       <= state_d;
      work        <= work_d;
      key_ready_o <= (state_d == S_ENTRY);
      out_valid_o <= (state_d == S_OUTPUT);
    end
  end

endmodule
